i2c_scl_gen: RTL and testbench



---
 rtl/i2c_scl_gen.sv | 139 +++++++++++++
 tb/tb_i2c_scl_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// I2C master SCL generator: runtime half-period, slave clock-stretch handling with
// timeout, phase tick strobes for the SDA shifter, and park-high on disable.
module i2c_scl_gen #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_CYCLES  = 4096,
  parameter int TMO_W       = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] half_period,
  input  logic             stretch_en,
  input  logic             scl_in,
  output logic             scl_out,
  output logic             fall_tick,
  output logic             rise_tick,
  output logic             mid_low_tick,
  output logic             mid_high_tick,
  output logic             stretching,
  output logic             stretch_tmo,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_STRETCH, S_HIGH} state_t;

  localparam logic [CNT_W-1:0] HP_MIN   = CNT_W'(4);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);
  localparam logic [TMO_W-1:0] STR_MIN  = TMO_W'(SYNC_STAGES + 1);
  localparam bit               TMO_ON   = (TMO_CYCLES != 0);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       hpe_q, hpe_d;
  logic [CNT_W-1:0]       hp_clamp;
  logic [TMO_W-1:0]       tcnt_q, tcnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   scl_sync;
  logic                   scl_sync_d;
  logic                   last_cnt;
  logic                   tmo_hit;

  assign hp_clamp   = (half_period < HP_MIN) ? HP_MIN : half_period;
  assign last_cnt   = (cnt_q == hpe_q - CNT_W'(1));
  assign scl_sync   = sync_q[SYNC_STAGES-1];
  // Value the synchroniser output will hold next cycle, so stretching can be registered.
  assign scl_sync_d = sync_q[SYNC_STAGES-2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hpe_d   = hpe_q;
    tcnt_d  = tcnt_q;
    tmo_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        tcnt_d = '0;
        if (enable) begin
          state_d = S_LOW;
          hpe_d   = hp_clamp;
        end
      end
      S_LOW: begin
        if (last_cnt) begin
          cnt_d = '0;
          if (stretch_en) begin
            state_d = S_STRETCH;
            tcnt_d  = '0;
          end else begin
            state_d = S_HIGH;
            hpe_d   = hp_clamp;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STRETCH: begin
        if (!stretch_en || scl_sync) begin
          state_d = S_HIGH;
          hpe_d   = hp_clamp;
        end else if (TMO_ON && tcnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          tmo_hit = 1'b1;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + TMO_W'(1);
        end
      end
      S_HIGH: begin
        if (last_cnt) begin
          cnt_d = '0;
          if (enable) begin
            state_d = S_LOW;
            hpe_d   = hp_clamp;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      hpe_q         <= '0;
      tcnt_q        <= '0;
      sync_q        <= '1;
      scl_out       <= 1'b1;
      fall_tick     <= 1'b0;
      rise_tick     <= 1'b0;
      mid_low_tick  <= 1'b0;
      mid_high_tick <= 1'b0;
      stretching    <= 1'b0;
      stretch_tmo   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hpe_q         <= hpe_d;
      tcnt_q        <= tcnt_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], scl_in};
      // Outputs are decoded from next-state values so every strobe is a flop output.
      scl_out       <= (state_d != S_LOW);
      fall_tick     <= (state_d == S_LOW)  && (state_q != S_LOW);
      rise_tick     <= (state_d == S_HIGH) && (state_q != S_HIGH);
      mid_low_tick  <= (state_d == S_LOW)  && (cnt_d == (hpe_d >> 1));
      mid_high_tick <= (state_d == S_HIGH) && (cnt_d == (hpe_d >> 1));
      stretching    <= (state_d == S_STRETCH) && (tcnt_d >= STR_MIN) && !scl_sync_d;
      stretch_tmo   <= tmo_hit;
      busy          <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Self-checking bench for i2c_scl_gen: measured-phase vector table, directed corner
// sequences, and per-cycle comparison against a phase-schedule reference model.
module tb_i2c_scl_gen;
  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int TMO   = 4096;
  localparam int TMO_W = 13;
  localparam logic [7:0] IDLE_OUT = 8'h80;

  logic             clk = 1'b0;
  logic             rst, enable, stretch_en, slave_rel;
  logic [CNT_W-1:0] half_period;
  logic             scl_in;
  logic             scl_out, fall_tick, rise_tick, mid_low_tick, mid_high_tick;
  logic             stretching, stretch_tmo, busy;

  // Wired-AND bus: slave can only pull the line low.
  assign scl_in = scl_out & slave_rel;

  always #5 clk = ~clk;

  i2c_scl_gen #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .TMO_CYCLES(TMO), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .half_period(half_period),
    .stretch_en(stretch_en), .scl_in(scl_in), .scl_out(scl_out),
    .fall_tick(fall_tick), .rise_tick(rise_tick), .mid_low_tick(mid_low_tick),
    .mid_high_tick(mid_high_tick), .stretching(stretching),
    .stretch_tmo(stretch_tmo), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {scl_out, fall_tick, rise_tick, mid_low_tick, mid_high_tick,
            stretching, stretch_tmo, busy};
  endfunction

  function automatic logic [7:0] mk(bit scl, bit fall, bit rise, bit ml, bit mh,
                                    bit str, bit tmo, bit bsy);
    return {scl, fall, rise, ml, mh, str, tmo, bsy};
  endfunction

  function automatic int hpe(int hp);
    return (hp < 4) ? 4 : hp;
  endfunction

  function automatic int rnd_hp(int fix);
    return (fix >= 0) ? fix : int'($urandom_range(0, 40));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; stretch_en = 1'b0; slave_rel = 1'b1;
    half_period = CNT_W'(49);
    step();
    rst = 1'b0;
  endtask

  // ---------------- reference schedule (one record per clock cycle) ----------------
  typedef struct {
    int         hp;
    bit         en;
    bit         se;
    bit         rel;
    logic [7:0] exp;
  } cyc_t;
  cyc_t sched[$];

  task automatic push(input int hp, input bit en, input bit se, input bit rel,
                      input logic [7:0] exp);
    cyc_t r;
    r.hp = hp; r.en = en; r.se = se; r.rel = rel; r.exp = exp;
    sched.push_back(r);
  endtask

  // Phases: LOW of HPe, optional stretch of hold+SYNC+1 cycles, HIGH of HPe. The
  // half-period is only meaningful on the cycle before a phase starts; elsewhere junk.
  task automatic build_run(input int nper, input bit se, input int fix_hp,
                           input int fix_h, input bit tmo_run);
    int hl, hh, h, lo, hi, g;
    bit last;
    sched.delete();
    hl = rnd_hp(fix_hp);
    push(hl, 1'b1, se, 1'b1, IDLE_OUT);
    for (int i = 0; i < nper; i++) begin
      lo = hpe(hl);
      hh = rnd_hp(fix_hp);
      h  = (fix_h >= 0) ? fix_h : int'($urandom_range(0, 15));
      for (int c = 0; c < lo; c++)
        push((!se && c == lo - 1) ? hh : rnd_hp(-1), 1'($urandom_range(0, 1)), se, 1'b1,
             mk(1'b0, c == 0, 1'b0, c == lo / 2, 1'b0, 1'b0, 1'b0, 1'b1));
      if (se && tmo_run) begin
        for (int k = 0; k < TMO; k++)
          push(rnd_hp(-1), 1'b0, se, 1'b0,
               mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, k >= SYNC + 1, 1'b0, 1'b1));
        push(rnd_hp(-1), 1'b0, se, 1'b1, mk(1'b1, 0, 0, 0, 0, 0, 1'b1, 1'b0));
        push(rnd_hp(-1), 1'b0, se, 1'b1, IDLE_OUT);
        push(rnd_hp(-1), 1'b0, se, 1'b1, IDLE_OUT);
        return;
      end
      if (se) begin
        g = h + SYNC + 1;
        for (int k = 0; k < g; k++)
          push((k == g - 1) ? hh : rnd_hp(-1), 1'($urandom_range(0, 1)), se, k >= h,
               mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (k >= SYNC + 1) && (k < h + SYNC), 1'b0, 1'b1));
      end
      hi   = hpe(hh);
      last = (i == nper - 1);
      if (!last) hl = rnd_hp(fix_hp);
      for (int c = 0; c < hi; c++)
        push((c == hi - 1 && !last) ? hl : rnd_hp(-1),
             (c == hi - 1) ? !last : 1'($urandom_range(0, 1)), se, 1'b1,
             mk(1'b1, 1'b0, c == 0, 1'b0, c == hi / 2, 1'b0, 1'b0, 1'b1));
    end
    push(rnd_hp(-1), 1'b0, se, 1'b1, IDLE_OUT);
    push(rnd_hp(-1), 1'b0, se, 1'b1, IDLE_OUT);
  endtask

  task automatic run_sched(input string tag);
    do_reset();
    for (int j = 0; j < sched.size(); j++) begin
      check($sformatf("%s[%0d]", tag, j), int'(outs()), int'(sched[j].exp));
      half_period = CNT_W'(sched[j].hp);
      enable      = sched[j].en;
      stretch_en  = sched[j].se;
      slave_rel   = sched[j].rel;
      step();
    end
  endtask

  // ---------------- phase measurement for table vectors ----------------
  task automatic measure(input int chg_t, input int new_hp, output int lo, output int gap,
                         output int hi, output int mid, output int first_fall);
    int t_hi = -1, t_rise = -1, t_fall2 = -1, t_mid = -1;
    enable = 1'b1;
    step();
    first_fall = int'(fall_tick);
    for (int t = 0; t < 400 && t_fall2 < 0; t++) begin
      if (t == chg_t) half_period = CNT_W'(new_hp);
      if (t > 0 && fall_tick) t_fall2 = t;
      if (rise_tick && t_rise < 0) t_rise = t;
      if (mid_low_tick && t_mid < 0) t_mid = t;
      if (scl_out && t_hi < 0) t_hi = t;
      step();
    end
    lo = t_hi; gap = t_rise - t_hi; hi = t_fall2 - t_rise; mid = t_mid;
    enable = 1'b0;
  endtask

  typedef struct {
    int hp;
    bit se;
    int lo;
    int gap;
    int hi;
    int mid;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int lo, gap, hi, mid, ff, cnt_busy, cnt_fall, cnt_rise, cnt_str, t_rise, junk;

    tbl[0] = '{49, 1'b0, 49, 0, 49, 24};
    tbl[1] = '{ 2, 1'b0,  4, 0,  4,  2};
    tbl[2] = '{ 0, 1'b0,  4, 0,  4,  2};
    tbl[3] = '{ 5, 1'b0,  5, 0,  5,  2};
    tbl[4] = '{49, 1'b1, 49, 3, 49, 24};
    tbl[5] = '{10, 1'b1, 10, 3, 10,  5};
    tbl[6] = '{ 4, 1'b1,  4, 3,  4,  2};

    do_reset();
    check("reset_outputs", int'(outs()), int'(IDLE_OUT));

    foreach (tbl[i]) begin
      do_reset();
      half_period = CNT_W'(tbl[i].hp);
      stretch_en  = tbl[i].se;
      measure(-1, 0, lo, gap, hi, mid, ff);
      check($sformatf("v%0d_first_fall", i), ff, 1);
      check($sformatf("v%0d_low_len", i), lo, tbl[i].lo);
      check($sformatf("v%0d_stretch_gap", i), gap, tbl[i].gap);
      check($sformatf("v%0d_high_len", i), hi, tbl[i].hi);
      check($sformatf("v%0d_mid_low_pos", i), mid, tbl[i].mid);
    end

    // Half-period change mid-LOW only affects the following phase.
    do_reset();
    half_period = CNT_W'(49);
    measure(10, 10, lo, gap, hi, junk, ff);
    check("hpchg_low_len", lo, 49);
    check("hpchg_high_len", hi, 10);

    // Enable dropped mid-LOW: LOW and HIGH complete, then park high.
    do_reset();
    half_period = CNT_W'(8);
    enable = 1'b1;
    step();
    cnt_busy = 0; cnt_fall = 0; cnt_rise = 0;
    for (int t = 0; t < 40; t++) begin
      if (t == 3) enable = 1'b0;
      cnt_busy += int'(busy);
      cnt_fall += int'(fall_tick);
      cnt_rise += int'(rise_tick);
      step();
    end
    check("dis_busy_cycles", cnt_busy, 16);
    check("dis_fall_count", cnt_fall, 1);
    check("dis_rise_count", cnt_rise, 1);
    check("dis_parked", int'(outs()), int'(IDLE_OUT));

    // Reset mid-LOW.
    do_reset();
    half_period = CNT_W'(20);
    enable = 1'b1;
    for (int t = 0; t < 6; t++) step();
    rst = 1'b1;
    step();
    check("rst_midlow", int'(outs()), int'(IDLE_OUT));
    rst = 1'b0; enable = 1'b0;
    cnt_fall = 0;
    for (int t = 0; t < 10; t++) begin
      cnt_fall += int'(outs() != IDLE_OUT);
      step();
    end
    check("rst_quiet", cnt_fall, 0);

    // stretch_en dropped while stretching.
    do_reset();
    half_period = CNT_W'(6);
    stretch_en = 1'b1;
    slave_rel = 1'b0;
    enable = 1'b1;
    step();
    t_rise = -1; cnt_str = 0;
    for (int t = 0; t < 40 && t_rise < 0; t++) begin
      if (t == 11) stretch_en = 1'b0;
      if (rise_tick) t_rise = t;
      cnt_str += int'(stretching);
      step();
    end
    check("sedrop_rise_at", t_rise, 12);
    check("sedrop_stretch_cycles", cnt_str, 3);
    slave_rel = 1'b1;

    build_run(3, 1'b1, 49, 0, 1'b0);
    run_sched("loopback");
    build_run(2, 1'b1, 49, 200, 1'b0);
    run_sched("hold200");
    build_run(1, 1'b1, 10, 0, 1'b1);
    run_sched("timeout");
    for (int r = 0; r < 10; r++) begin
      build_run(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), -1, -1, 1'b0);
      run_sched($sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
